// File: rtl/pipelined_select_biggest_if.sv
// Request/result bundle for pipelined_select_biggest.
// master: producer/consumer side; slave: the selector itself.
interface pipelined_select_biggest_if #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16,
  parameter int NUM_WAY_INDEX_WIDTH      = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) ();
  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in;
  logic [NUM_WAY-1:0]                          condition_in;
  logic                                        mode_in;
  logic                                        request_valid_in;
  logic                                        request_ready_out;
  logic                                        select_valid_out;
  logic                                        select_ready_in;
  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         select_out;
  logic [NUM_WAY_INDEX_WIDTH-1:0]              select_index_out;
  logic                                        select_found_out;

  modport master (
    output way_flatted_in, condition_in, mode_in, request_valid_in, select_ready_in,
    input  request_ready_out, select_valid_out, select_out, select_index_out, select_found_out
  );

  modport slave (
    input  way_flatted_in, condition_in, mode_in, request_valid_in, select_ready_in,
    output request_ready_out, select_valid_out, select_out, select_index_out, select_found_out
  );
endinterface

// File: rtl/pipelined_select_biggest.sv
// Pipelined max/min selector over NUM_WAY ways. One comparator-tree level per
// register stage, heap-indexed: node n combines children 2n (lower) and 2n+1.
// Leaves (P..2P-1) are the padded input ways; node 1 is the root.
module pipelined_select_biggest #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16,
  parameter int NUM_WAY_INDEX_WIDTH      = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
  input logic                       clk_in,
  input logic                       reset_in,
  pipelined_select_biggest_if.slave bus
);
  localparam int W       = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int IW      = NUM_WAY_INDEX_WIDTH;
  localparam int LEVELS  = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 0;
  localparam int LATENCY = (LEVELS > 1) ? LEVELS : 1;
  localparam int P       = 1 << LEVELS;

  logic              stall;
  logic [LATENCY:1]  valid_q;
  logic [W-1:0]      root_val;
  logic [IW-1:0]     root_idx;
  logic              root_cand;

  assign stall                 = bus.select_valid_out & ~bus.select_ready_in;
  assign bus.request_ready_out = ~stall;

  // Stage valid bits: shift on every non-stall edge, bubbles included.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[1] <= bus.request_valid_in;
      for (int unsigned s = 2; s <= LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  if (NUM_WAY == 1) begin : g_single
    logic [W-1:0] val_q;
    logic         cand_q;

    // Single way: one register stage, no comparison needed.
    always_ff @(posedge clk_in) begin
      if (!stall) begin
        val_q  <= bus.way_flatted_in[W-1:0];
        cand_q <= bus.condition_in[0];
      end
    end

    assign root_val  = val_q;
    assign root_idx  = '0;
    assign root_cand = cand_q;
  end else begin : g_tree
    localparam int PW = P * W;

    logic [PW-1:0]     ways_pad;
    logic [P-1:0]      cond_pad;
    logic [LEVELS-1:0] mode_chain;  // mode of data entering level l is mode_chain[l-1]

    logic [W-1:0]  kid_val  [2:2*P-1];
    logic [IW-1:0] kid_idx  [2:2*P-1];
    logic          kid_cand [2:2*P-1];

    logic [W-1:0]  node_val_q  [1:P-1];
    logic [W-1:0]  node_val_d  [1:P-1];
    logic [IW-1:0] node_idx_q  [1:P-1];
    logic [IW-1:0] node_idx_d  [1:P-1];
    logic          node_cand_q [1:P-1];
    logic          node_cand_d [1:P-1];

    // Padding ways beyond NUM_WAY are zero with cand=0, so they never win.
    assign ways_pad      = PW'(bus.way_flatted_in);
    assign cond_pad      = P'(bus.condition_in);
    assign mode_chain[0] = bus.mode_in;

    if (LEVELS > 1) begin : g_mode
      logic [LEVELS-1:1] mode_q;

      // Mode rides alongside the data of each non-root stage.
      always_ff @(posedge clk_in) begin
        if (!stall) begin
          mode_q <= mode_chain[LEVELS-2:0];
        end
      end

      assign mode_chain[LEVELS-1:1] = mode_q;
    end

    // Comparator tree: every node's next value from its two children.
    always_comb begin
      int unsigned n;
      int unsigned lo;
      int unsigned hi;
      logic        h_wins;
      n      = 0;
      lo     = 0;
      hi     = 0;
      h_wins = 1'b0;
      node_val_d  = node_val_q;
      node_idx_d  = node_idx_q;
      node_cand_d = node_cand_q;
      for (int unsigned i = 2; i < P; i++) begin
        kid_val[i]  = node_val_q[i];
        kid_idx[i]  = node_idx_q[i];
        kid_cand[i] = node_cand_q[i];
      end
      for (int unsigned i = P; i < 2*P; i++) begin
        kid_val[i]  = ways_pad[(i-P)*W +: W];
        kid_idx[i]  = IW'(i - P);
        kid_cand[i] = cond_pad[i-P];
      end
      for (int unsigned l = 1; l <= LEVELS; l++) begin
        for (int unsigned k = 0; k < (P >> l); k++) begin
          n  = (P >> l) + k;
          lo = 2 * n;
          hi = lo + 1;
          // Strict compare: ties keep the lower-index node.
          h_wins = kid_cand[hi] & (~kid_cand[lo] |
                   (mode_chain[l-1] ? (kid_val[hi] < kid_val[lo])
                                    : (kid_val[hi] > kid_val[lo])));
          node_val_d[n]  = h_wins ? kid_val[hi] : kid_val[lo];
          node_idx_d[n]  = h_wins ? kid_idx[hi] : kid_idx[lo];
          node_cand_d[n] = kid_cand[lo] | kid_cand[hi];
        end
      end
    end

    // Tree registers hold together with the valid bits during a stall.
    always_ff @(posedge clk_in) begin
      if (!stall) begin
        node_val_q  <= node_val_d;
        node_idx_q  <= node_idx_d;
        node_cand_q <= node_cand_d;
      end
    end

    assign root_val  = node_val_q[1];
    assign root_idx  = node_idx_q[1];
    assign root_cand = node_cand_q[1];
  end

  // Data registers are not reset; gating by valid gives zero outputs after reset.
  assign bus.select_valid_out = valid_q[LATENCY];
  assign bus.select_found_out = valid_q[LATENCY] & root_cand;
  assign bus.select_out       = bus.select_found_out ? root_val : '0;
  assign bus.select_index_out = bus.select_found_out ? root_idx : '0;
endmodule

// File: tb/tb_pipelined_select_biggest.sv
// Directed bench for pipelined_select_biggest: 16x4 and 5x8 instances.
module tb_pipelined_select_biggest;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_select_biggest_if #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(16)) bus16 ();
  pipelined_select_biggest_if #(.SINGLE_WAY_WIDTH_IN_BITS(8), .NUM_WAY(5))  bus5 ();

  pipelined_select_biggest #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(16)) dut16 (
    .clk_in(clk), .reset_in(rst), .bus(bus16)
  );
  pipelined_select_biggest #(.SINGLE_WAY_WIDTH_IN_BITS(8), .NUM_WAY(5)) dut5 (
    .clk_in(clk), .reset_in(rst), .bus(bus5)
  );

  localparam logic [63:0] WAYS_A = 64'hABCD_5234_5234_ABA5;
  localparam logic [15:0] COND_A = 16'b1110_0111_1110_0111;
  localparam logic [63:0] WAYS_7 = 64'h7777_7777_7777_7777;
  localparam logic [39:0] WAYS_5 = {8'd255, 8'd3, 8'd200, 8'd200, 8'd10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out16(input string tag, input logic v, input logic [3:0] ev,
                             input logic [3:0] ei, input logic ef);
    check_eq({tag, "_valid"}, 32'(bus16.select_valid_out), 32'(v));
    check_eq({tag, "_val"},   32'(bus16.select_out),       32'(ev));
    check_eq({tag, "_idx"},   32'(bus16.select_index_out), 32'(ei));
    check_eq({tag, "_found"}, 32'(bus16.select_found_out), 32'(ef));
  endtask

  // One request on the 16-way instance, latency 4 (visible after accept edge + 3).
  task automatic run16(input string tag, input logic [63:0] ways, input logic [15:0] cond,
                       input logic mode, input logic [3:0] ev, input logic [3:0] ei,
                       input logic ef);
    bus16.way_flatted_in   = ways;
    bus16.condition_in     = cond;
    bus16.mode_in          = mode;
    bus16.request_valid_in = 1'b1;
    check_eq({tag, "_rdy"}, 32'(bus16.request_ready_out), 32'd1);
    tick();
    bus16.request_valid_in = 1'b0;
    bus16.way_flatted_in   = ~ways;
    bus16.condition_in     = ~cond;
    bus16.mode_in          = ~mode;
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_early"}, 32'(bus16.select_valid_out), 32'd0);
      tick();
    end
    check_out16(tag, 1'b1, ev, ei, ef);
    tick();
    check_eq({tag, "_drain"}, 32'(bus16.select_valid_out), 32'd0);
  endtask

  // One request on the 5-way instance, latency 3.
  task automatic run5(input string tag, input logic [4:0] cond, input logic mode,
                      input logic [7:0] ev, input logic [2:0] ei, input logic ef);
    bus5.way_flatted_in   = WAYS_5;
    bus5.condition_in     = cond;
    bus5.mode_in          = mode;
    bus5.request_valid_in = 1'b1;
    tick();
    bus5.request_valid_in = 1'b0;
    bus5.way_flatted_in   = '0;
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_early"}, 32'(bus5.select_valid_out), 32'd0);
      tick();
    end
    check_eq({tag, "_valid"}, 32'(bus5.select_valid_out), 32'd1);
    check_eq({tag, "_val"},   32'(bus5.select_out),       32'(ev));
    check_eq({tag, "_idx"},   32'(bus5.select_index_out), 32'(ei));
    check_eq({tag, "_found"}, 32'(bus5.select_found_out), 32'(ef));
    tick();
    check_eq({tag, "_drain"}, 32'(bus5.select_valid_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus16.way_flatted_in   = '0;
    bus16.condition_in     = '0;
    bus16.mode_in          = 1'b0;
    bus16.request_valid_in = 1'b1;
    bus16.select_ready_in  = 1'b1;
    bus5.way_flatted_in    = '0;
    bus5.condition_in      = '0;
    bus5.mode_in           = 1'b0;
    bus5.request_valid_in  = 1'b0;
    bus5.select_ready_in   = 1'b1;
    tick();
    tick();
    bus16.request_valid_in = 1'b0;
    rst = 1'b0;
    check_out16("reset", 1'b0, 4'h0, 4'd0, 1'b0);
    check_eq("reset_rdy", 32'(bus16.request_ready_out), 32'd1);
    check_eq("reset5_valid", 32'(bus5.select_valid_out), 32'd0);
    tick();

    run16("max",     WAYS_A, COND_A,   1'b0, 4'hC, 4'd13, 1'b1);
    run16("min",     WAYS_A, COND_A,   1'b1, 4'h2, 4'd6,  1'b1);
    run16("ties7",   WAYS_7, 16'hFFFF, 1'b0, 4'h7, 4'd0,  1'b1);
    run16("nocond",  WAYS_7, 16'h0000, 1'b0, 4'h0, 4'd0,  1'b0);

    // Backpressure: three back-to-back requests into a stalled consumer.
    bus16.select_ready_in  = 1'b0;
    bus16.way_flatted_in   = WAYS_A;
    bus16.condition_in     = COND_A;
    bus16.mode_in          = 1'b0;
    bus16.request_valid_in = 1'b1;
    tick();
    bus16.condition_in = 16'hFFFF;
    tick();
    bus16.condition_in = COND_A;
    bus16.mode_in      = 1'b1;
    tick();
    bus16.request_valid_in = 1'b0;
    tick();
    check_out16("bp_first", 1'b1, 4'hC, 4'd13, 1'b1);
    check_eq("bp_rdy_low", 32'(bus16.request_ready_out), 32'd0);
    bus16.request_valid_in = 1'b1;
    bus16.way_flatted_in   = WAYS_7;
    bus16.condition_in     = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out16("bp_hold", 1'b1, 4'hC, 4'd13, 1'b1);
      check_eq("bp_hold_rdy", 32'(bus16.request_ready_out), 32'd0);
    end
    bus16.request_valid_in = 1'b0;
    bus16.select_ready_in  = 1'b1;
    #1;
    check_eq("bp_rdy_back", 32'(bus16.request_ready_out), 32'd1);
    tick();
    check_out16("bp_second", 1'b1, 4'hD, 4'd12, 1'b1);
    tick();
    check_out16("bp_third", 1'b1, 4'h2, 4'd6, 1'b1);
    tick();
    check_eq("bp_nodup", 32'(bus16.select_valid_out), 32'd0);
    tick();
    check_eq("bp_nodup2", 32'(bus16.select_valid_out), 32'd0);

    // Reset with two requests in flight.
    bus16.way_flatted_in   = WAYS_A;
    bus16.condition_in     = COND_A;
    bus16.mode_in          = 1'b0;
    bus16.request_valid_in = 1'b1;
    tick();
    bus16.mode_in = 1'b1;
    tick();
    bus16.request_valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out16("rst_mid", 1'b0, 4'h0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rst_nostale", 32'(bus16.select_valid_out), 32'd0);
    end
    run16("post_rst", WAYS_7, 16'hFFFF, 1'b0, 4'h7, 4'd0, 1'b1);

    // Five-way, non-power-of-two instance.
    run5("w5_max",  5'b01111, 1'b0, 8'd200, 3'd1, 1'b1);
    run5("w5_top",  5'b10000, 1'b0, 8'd255, 3'd4, 1'b1);
    run5("w5_min",  5'b01111, 1'b1, 8'd3,   3'd3, 1'b1);
    run5("w5_none", 5'b00000, 1'b0, 8'd0,   3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_select_biggest.md
Name: pipelined_select_biggest

Overview:
Pipelined, parametrised successor to the combinational select_biggest. It reduces NUM_WAY ways to a single winner using a registered comparator tree, one tree level per stage. The winner is the largest way (or, at runtime, the smallest) among the ways whose condition bit is set, and the block reports both its value and its way index. A valid/ready handshake with full-pipeline backpressure lets it sit between streaming producer and consumer stages in the arbitration and replacement logic.

Parameters:
SINGLE_WAY_WIDTH_IN_BITS, 4, width of each way value (>=1)
NUM_WAY, 16, number of ways (>=1; non-power-of-two allowed)
NUM_WAY_INDEX_WIDTH, $clog2(NUM_WAY) (min 1), width of the index output
LATENCY, max(1, $clog2(NUM_WAY)), number of register stages, derived; do not override

Ports:
clk_in  input  1  clock; all state updates on rising edge
reset_in  input  1  synchronous, active-high reset
way_flatted_in  input  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  packed ways, way i at bits [i*W +: W]
condition_in  input  NUM_WAY  bit i=1 makes way i a candidate
mode_in  input  1  0 = select biggest, 1 = select smallest; sampled with the request
request_valid_in  input  1  request present
request_ready_out  output  1  block can accept a request this cycle
select_valid_out  output  1  result present
select_ready_in  input  1  downstream accepts the result
select_out  output  SINGLE_WAY_WIDTH_IN_BITS  winning value
select_index_out  output  NUM_WAY_INDEX_WIDTH  winning way index
select_found_out  output  1  at least one condition bit was set

Behaviour:
- Reset (synchronous, reset_in=1 at an edge): all stage valid bits cleared. After reset: select_valid_out=0, select_out=0, select_index_out=0, select_found_out=0. Reset overrides any in-flight request or simultaneous accept; in-flight requests are discarded, never emitted.
- Stall: stall = select_valid_out & ~select_ready_in. request_ready_out = ~stall (combinational). While stall=1, every stage holds its contents, including bubbles.
- Accept: a request is taken at an edge where request_valid_in & request_ready_out. Otherwise a bubble enters stage 1 on a non-stall edge.
- Latency: a request accepted at edge t appears on the outputs, with select_valid_out=1, after edge t+LATENCY-1 when there is no stall. Stall cycles add 1:1. Requests emerge in order. Throughput is 1 per cycle when select_ready_in=1.
- Tree: level 0 holds (value, index, cand) per way, with cand = condition_in[i].
  - Ways are padded to the next power of two with cand=0.
  - Each level pairs node 2k (lower index) with node 2k+1.
  - mode travels with the data through every stage.
- Pair rule, lower-index node L vs higher-index node H:
  - only one node is a cand: that node wins.
  - neither is a cand: L wins, and the result has cand=0.
  - both are cands: in mode 0, H wins iff H.value > L.value; in mode 1, H wins iff H.value < L.value. Ties go to L, so among equal extremes the lowest index wins.
- Output fields:
  - select_found_out is the root cand.
  - If found=0: select_out=0 and select_index_out=0.
  - Otherwise select_out and select_index_out are the root value and index.
  - Comparison is unsigned at full width; there is no overflow path.
- NUM_WAY=1: one register stage. The result is way 0, and found=condition_in[0].
- Output fields are don't-care for checking while select_valid_out=0, except after reset, where they are 0.
- Changes to inputs while not accepted have no effect.

Test Plan:
- Directed max: W=4, N=16, ways 15..0 = a,b,c,d,5,2,3,4,5,2,3,4,a,b,a,5, condition=16'b1110_0111_1110_0111, mode 0 -> select_out=4'hc, index=13, found=1, valid exactly 4 cycles after accept.
- Same ways, mode 1 -> select_out=4'h2, index=6 (tie with way 10 resolves to lower index), found=1.
- All ways 4'h7, condition=16'hFFFF, mode 0 -> select_out=7, index=0. condition=16'h0000 -> found=0, select_out=0, index=0.
- Backpressure: 3 back-to-back requests (expected 4'hc, 4'hd, 4'h2) with select_ready_in=0 from cycle 3. Required: request_ready_out drops while valid_out is held, outputs stay stable, and after releasing ready the results arrive in order with no loss or duplication.
- Reset mid-stream: accept 2 requests, assert reset_in for 1 cycle before either emerges -> select_valid_out=0 with all output fields 0 next cycle, no stale result ever appears, and a new request afterwards completes with normal latency.
- NUM_WAY=5, W=8 instance: ways 0..4 = 10,200,200,3,255, condition=5'b01111 -> select_out=200, index=1, latency 3. With condition=5'b10000 -> select_out=255, index=4.
